control_cmd_dispatch: RTL and testbench
=======================================

# control_cmd_dispatch

Command front end between the byte receiver and the `control_cmd_*` sub-command engines. It takes the received byte stream, decodes the leading opcode byte, and forwards every following byte as a one-cycle enable/data strobe to exactly one sub-command engine. It holds that route until the engine reports `done`. The opcode byte is never forwarded, so each engine sees only its own payload; for example, `control_cmd_readrow` sees the row selector followed by pixel bytes.

## Interface
Parameters:
- `OPCODE_0`, 8'h52 ('R'), opcode routed to channel 0 (readrow)
- `OPCODE_1`, 8'h50 ('P'), opcode routed to channel 1
- `OPCODE_2`, 8'h46 ('F'), opcode routed to channel 2
- `OPCODE_3`, 8'h42 ('B'), opcode routed to channel 3
- `TIMEOUT_CYCLES`, 4096, maximum clk cycles allowed between successive forwarded bytes, or between the last byte and `done`; must be ≥ 2

Ports:
- `clk` in 1: system clock
- `reset` in 1: reset, asynchronous, active-low
- `rx_data` in 8: received byte
- `rx_valid` in 1: single-cycle strobe, `rx_data` valid
- `sub_done` in 4: per-channel done pulse from the sub-command engines
- `sub_enable` out 4: one-hot per-byte strobe to the engines
- `sub_data` out 8: byte accompanying `sub_enable`
- `busy` out 1: high while a route is held
- `active_cmd` out 2: index of the routed channel; meaningful only while `busy` is high
- `byte_count` out 16: payload bytes forwarded in the current command; saturates at 16'hFFFF
- `err_opcode` out 1: one-cycle pulse when an unknown opcode is received
- `err_timeout` out 1: one-cycle pulse when the watchdog aborts a command

## Operation
- Reset values (all outputs registered): `sub_enable`=0, `sub_data`=0, `busy`=0, `active_cmd`=0, `byte_count`=0, `err_opcode`=0, `err_timeout`=0, state=IDLE.
- **IDLE**:
  - `rx_valid` with `rx_data` equal to `OPCODE_n` → latch n into `active_cmd`, clear `byte_count`, go to ROUTE.
  - If opcodes collide, the lowest n wins.
  - Any other byte → pulse `err_opcode` and stay in IDLE; the byte is dropped.
- **ROUTE**:
  - `rx_valid` → `sub_data` <= `rx_data`, `sub_enable[active_cmd]` <= 1 for one cycle, increment `byte_count`.
  - `sub_done[active_cmd]` → go to IDLE and set `busy` <= 0.
  - `sub_done` bits of inactive channels are ignored.
- **Simultaneous `rx_valid` and `sub_done[active_cmd]` in ROUTE**: the byte is not forwarded. It is decoded as the next opcode, exactly as IDLE would decode it, so the FSM can go ROUTE→ROUTE on a new channel in a single cycle.
- **Watchdog**: a counter is cleared on entry to ROUTE and on every forwarded byte, and increments otherwise while in ROUTE. When it reaches `TIMEOUT_CYCLES`:
  - pulse `err_timeout`, go to IDLE, set `busy` <= 0;
  - no `sub_enable` is issued that cycle.
- **Reset mid-command**: all state clears immediately and asynchronously; the engines must be reset by the same signal.
- `sub_enable` is never multi-hot and never asserted outside ROUTE.

## Timing
- Latency from `rx_valid` to `sub_enable`/`sub_data` is exactly 1 clk; `sub_enable` is high for exactly 1 clk per byte.
- `busy` and `active_cmd` update the cycle after the opcode `rx_valid`. The earliest forwardable byte is the next `rx_valid`, which may arrive on the very next cycle.
- `busy` falls the cycle after `sub_done[active_cmd]` is sampled.
- Back-to-back `rx_valid` (every cycle) is supported with no byte loss.
- `err_opcode` and `err_timeout` are asserted 1 clk after the triggering sample, for 1 clk.

## Configuration
- `CMD_DISPATCH_TIMEOUT_EN`:
  - Defined: the watchdog is implemented as described.
  - Undefined: no counter is built, `err_timeout` is tied 0, and ROUTE is exited only by `sub_done[active_cmd]` or reset.

## Test plan
- **Reset**: hold `reset`=0 for 3 clks → all outputs 0. Release reset with no stimulus → outputs stay 0.
- **Readrow route**: send 8'h52, 8'h03, 8'hAA, 8'h55, then pulse `sub_done[0]` → `sub_enable`=4'b0001 three times carrying 03/AA/55, each 1 clk after its `rx_valid`; `byte_count`=3; `busy` drops 1 clk after `done`; 8'h52 is never forwarded.
- **Unknown opcode**: 8'h00 in IDLE → one `err_opcode` pulse, `busy` stays 0. A following 8'h50 routes to channel 1 (`active_cmd`=1).
- **Done coincident with byte**: in ROUTE on channel 0, `sub_done[0]` and `rx_valid` with 8'h46 in the same cycle → no `sub_enable`; next cycle `busy`=1, `active_cmd`=2. The next byte 8'h11 yields `sub_enable`=4'b0100.
- **Watchdog** (macro defined, `TIMEOUT_CYCLES`=16): 8'h52, 8'h01, then silence → `err_timeout` pulses 16 clks after the 8'h01 strobe, `busy`=0. Without the macro, `busy` remains 1 after 1000 clks.
- **Stray done and reset abort**: `sub_done[3]` while routed to channel 0 → ignored. `reset` low mid-payload → immediate return to IDLE, outputs 0.

Source files
------------

// File: rtl/control_cmd_dispatch_if.sv
// Byte-stream and sub-engine strobe bundle for control_cmd_dispatch.
// The master side is the dispatcher and the slave side is the receiver plus engine environment.
interface control_cmd_dispatch_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] sub_done;
  logic [3:0] sub_enable;
  logic [7:0] sub_data;

  modport master (
    input  rx_data,
    input  rx_valid,
    input  sub_done,
    output sub_enable,
    output sub_data
  );

  modport slave (
    output rx_data,
    output rx_valid,
    output sub_done,
    input  sub_enable,
    input  sub_data
  );
endinterface

// File: rtl/control_cmd_dispatch.sv
// Decodes a leading opcode byte and routes each following byte as a 1-clk strobe to one engine until its done.
// Optional watchdog abort is built only when CMD_DISPATCH_TIMEOUT_EN is defined.
module control_cmd_dispatch #(
  parameter logic [7:0] OPCODE_0       = 8'h52,
  parameter logic [7:0] OPCODE_1       = 8'h50,
  parameter logic [7:0] OPCODE_2       = 8'h46,
  parameter logic [7:0] OPCODE_3       = 8'h42,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  control_cmd_dispatch_if.master        bus,
  output logic                          busy,
  output logic [1:0]                    active_cmd,
  output logic [15:0]                   byte_count,
  output logic                          err_opcode,
  output logic                          err_timeout
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("control_cmd_dispatch: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {IDLE, ROUTE} state_t;
  state_t state;

  logic       op_hit;
  logic [1:0] op_idx;
  logic       done_act;

  // Lowest channel wins if two opcode parameters are configured equal.
  always_comb begin
    op_hit = 1'b1;
    op_idx = 2'd0;
    if (bus.rx_data == OPCODE_0)      op_idx = 2'd0;
    else if (bus.rx_data == OPCODE_1) op_idx = 2'd1;
    else if (bus.rx_data == OPCODE_2) op_idx = 2'd2;
    else if (bus.rx_data == OPCODE_3) op_idx = 2'd3;
    else                              op_hit = 1'b0;
    done_act = bus.sub_done[active_cmd];
  end

`ifdef CMD_DISPATCH_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      bus.sub_enable <= 4'd0;
      bus.sub_data   <= 8'd0;
      busy           <= 1'b0;
      active_cmd     <= 2'd0;
      byte_count     <= 16'd0;
      err_opcode     <= 1'b0;
      err_timeout    <= 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
      wd             <= '0;
`endif
    end else begin
      bus.sub_enable <= 4'd0;
      err_opcode     <= 1'b0;
      err_timeout    <= 1'b0;
      // A byte arriving with the active done is decoded as the next opcode, never forwarded.
      if (state == IDLE || done_act) begin
        if (bus.rx_valid && op_hit) begin
          state      <= ROUTE;
          busy       <= 1'b1;
          active_cmd <= op_idx;
          byte_count <= 16'd0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
          wd         <= '0;
`endif
        end else begin
          state      <= IDLE;
          busy       <= 1'b0;
          err_opcode <= bus.rx_valid;
        end
      end else if (bus.rx_valid) begin
        bus.sub_enable <= 4'd1 << active_cmd;
        bus.sub_data   <= bus.rx_data;
        if (byte_count != 16'hFFFF) byte_count <= byte_count + 16'd1;
`ifdef CMD_DISPATCH_TIMEOUT_EN
        wd             <= '0;
      end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
        state       <= IDLE;
        busy        <= 1'b0;
        err_timeout <= 1'b1;
      end else begin
        wd <= wd + WD_W'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_control_cmd_dispatch.sv
// Randomized + directed bench for control_cmd_dispatch with a queue scoreboard and a command-level model.
`timescale 1ns/1ps
module tb_control_cmd_dispatch;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic [1:0]  active_cmd;
  logic [15:0] byte_count;
  logic        err_opcode;
  logic        err_timeout;

  control_cmd_dispatch_if bus();

  control_cmd_dispatch #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .active_cmd  (active_cmd),
    .byte_count  (byte_count),
    .err_opcode  (err_opcode),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         ch;
    logic [7:0] dat;
  } en_t;

  en_t  en_q[$];
  int   eop_q[$];
  int   eto_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [7:0] ops [4] = '{8'h52, 8'h50, 8'h46, 8'h42};

  // Command-level model: which channel owns the route, payload count, silent cycles.
  bit m_route = 0;
  int m_ch = 0;
  int m_cnt = 0;
  int m_gap = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int decode(logic [7:0] b);
    for (int n = 0; n < 4; n++) if (b == ops[n]) return n;
    return -1;
  endfunction

  // Monitor: compares whatever the DUT presents against the head of each expectation queue.
  always @(negedge clk) begin
    if (reset) begin
      if (en_q.size() != 0 && en_q[0].due <= cyc) begin
        en_t e;
        e = en_q.pop_front();
        chk("sub_enable", 32'(bus.sub_enable), 32'(1) << e.ch);
        chk("sub_data", 32'(bus.sub_data), 32'(e.dat));
      end else begin
        chk("sub_enable_quiet", 32'(bus.sub_enable), 32'd0);
      end
      if (eop_q.size() != 0 && eop_q[0] <= cyc) begin
        void'(eop_q.pop_front());
        chk("err_opcode_pulse", 32'(err_opcode), 32'd1);
      end else begin
        chk("err_opcode_quiet", 32'(err_opcode), 32'd0);
      end
      if (eto_q.size() != 0 && eto_q[0] <= cyc) begin
        void'(eto_q.pop_front());
        chk("err_timeout_pulse", 32'(err_timeout), 32'd1);
      end else begin
        chk("err_timeout_quiet", 32'(err_timeout), 32'd0);
      end
    end
  end

  task automatic step(input bit rv, input logic [7:0] rd, input logic [3:0] dn);
    int n;
    en_t e;
    bus.rx_valid = rv;
    bus.rx_data  = rd;
    bus.sub_done = dn;
    if (!m_route || dn[m_ch]) begin
      m_route = 0;
      if (rv) begin
        n = decode(rd);
        if (n >= 0) begin
          m_route = 1; m_ch = n; m_cnt = 0; m_gap = 0;
        end else begin
          eop_q.push_back(cyc + 1);
        end
      end
    end else if (rv) begin
      e.due = cyc + 1; e.ch = m_ch; e.dat = rd;
      en_q.push_back(e);
      if (m_cnt < 65535) m_cnt++;
      m_gap = 0;
    end else begin
`ifdef CMD_DISPATCH_TIMEOUT_EN
      m_gap++;
      if (m_gap == TO) begin
        m_route = 0;
        eto_q.push_back(cyc + 1);
      end
`endif
    end
    @(negedge clk);
    chk("busy", 32'(busy), 32'(m_route));
    if (m_route) chk("active_cmd", 32'(active_cmd), 32'(m_ch));
    chk("byte_count", 32'(byte_count), 32'(m_cnt));
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_sub_enable"}, 32'(bus.sub_enable), 32'd0);
    chk({tag, "_sub_data"}, 32'(bus.sub_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_active_cmd"}, 32'(active_cmd), 32'd0);
    chk({tag, "_byte_count"}, 32'(byte_count), 32'd0);
    chk({tag, "_err_opcode"}, 32'(err_opcode), 32'd0);
    chk({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  // Asserts reset between edges, so the clear must be visible without any clock.
  task automatic do_reset();
    #2 reset = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'd0; bus.sub_done = 4'd0;
    #1 check_all_zero("reset_async");
    m_route = 0; m_ch = 0; m_cnt = 0; m_gap = 0;
    en_q.delete(); eop_q.delete(); eto_q.delete();
    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    reset = 1'b1;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    bus.sub_done = 4'd0;
    do_reset();
    repeat (3) step(0, 8'h00, 4'd0);
    check_all_zero("post_reset_idle");

    // Readrow route.
    step(1, 8'h52, 4'd0);
    step(1, 8'h03, 4'd0);
    step(1, 8'hAA, 4'd0);
    step(1, 8'h55, 4'd0);
    step(0, 8'h00, 4'b0001);
    chk("readrow_count", 32'(byte_count), 32'd3);
    step(0, 8'h00, 4'd0);

    // Unknown opcode then channel 1.
    step(1, 8'h00, 4'd0);
    step(1, 8'h50, 4'd0);
    chk("route_ch1", 32'(active_cmd), 32'd1);
    step(1, 8'h7E, 4'd0);
    step(0, 8'h00, 4'b0010);

    // Done coincident with a new opcode.
    step(1, 8'h52, 4'd0);
    step(1, 8'h01, 4'd0);
    step(1, 8'h46, 4'b0001);
    chk("handover_ch2", 32'(active_cmd), 32'd2);
    step(1, 8'h11, 4'd0);
    step(0, 8'h00, 4'b0100);

    // Stray done on an inactive channel.
    step(1, 8'h52, 4'd0);
    step(0, 8'h00, 4'b1000);
    step(1, 8'h99, 4'd0);
    step(0, 8'h00, 4'b1110);
    step(0, 8'h00, 4'b0001);

    // Silence after a byte.
    step(1, 8'h52, 4'd0);
    step(1, 8'h01, 4'd0);
`ifdef CMD_DISPATCH_TIMEOUT_EN
    repeat (TO + 4) step(0, 8'h00, 4'd0);
    chk("busy_after_timeout", 32'(busy), 32'd0);
`else
    repeat (1000) step(0, 8'h00, 4'd0);
    chk("busy_after_silence", 32'(busy), 32'd1);
    step(0, 8'h00, 4'b0001);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit         rv;
      logic [7:0] rd;
      logic [3:0] dn;
      rv = ($urandom_range(0, 99) < 60);
      if (!m_route && $urandom_range(0, 4) != 0) rd = ops[$urandom_range(0, 3)];
      else if ($urandom_range(0, 7) == 0) rd = ops[$urandom_range(0, 3)];
      else rd = 8'($urandom);
      dn = 4'd0;
      if ($urandom_range(0, 99) < 6) dn = 4'(1 << $urandom_range(0, 3));
      else if ($urandom_range(0, 99) < 2) dn = 4'($urandom);
      step(rv, rd, dn);
      if ($urandom_range(0, 199) == 0) repeat (TO + 4) step(0, 8'h00, 4'd0);
    end

    // Reset in the middle of a payload.
    step(0, 8'h00, 4'b1111);
    step(1, 8'h42, 4'd0);
    step(1, 8'h21, 4'd0);
    step(1, 8'h22, 4'd0);
    do_reset();
    repeat (3) step(0, 8'h00, 4'd0);
    check_all_zero("post_abort_idle");

    chk("en_q_drained", 32'(en_q.size()), 32'd0);
    chk("eop_q_drained", 32'(eop_q.size()), 32'd0);
    chk("eto_q_drained", 32'(eto_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
